// File: rtl/csr_access_unit.sv
// csr_access_unit: executes one Zicsr instruction against the CSR register file.
// Accepts an instruction and its rs1 value, reads the addressed CSR, performs the
// read-modify-write through the file's write port and returns the old value.
// Optional build macro: CSR_RO_TRAP_EN turns writes to read-only CSR space
// (address bits [11:10] == 2'b11) into illegal-instruction responses.
module csr_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_instr,
  input  logic [XLEN-1:0] req_rs1_val,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      resp_rd_addr,
  output logic            resp_rd_we,
  output logic [XLEN-1:0] resp_rd_val,
  output logic            resp_illegal,
  output logic [3:0]      csr_ctrl,
  output logic [31:0]     csr_instr,
  output logic [XLEN-1:0] csr_wd,
  input  logic [XLEN-1:0] csr_rdata
);

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] operand_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] new_q;
  logic            illegal_q;

  logic            accept;
  logic [2:0]      funct3;
  logic            is_rw;
  logic            wants_write;
  logic            ro_viol;
  logic            illegal_c;
  logic [XLEN-1:0] new_c;

  // Bitwise read-modify-write selected by funct3[1:0]; 00 is illegal and yields old.
  function automatic logic [XLEN-1:0] csr_rmw(input logic [1:0] op,
                                              input logic [XLEN-1:0] old_val,
                                              input logic [XLEN-1:0] opnd);
    logic [XLEN-1:0] res;
    case (op)
      2'b01:   res = opnd;
      2'b10:   res = old_val | opnd;
      2'b11:   res = old_val & ~opnd;
      default: res = old_val;
    endcase
    return res;
  endfunction

  assign accept = req_valid && req_ready;
  assign funct3 = instr_q[14:12];
  assign is_rw  = (funct3[1:0] == 2'b01);

  // csrrw/csrrwi always write; set/clear forms write only with a nonzero rs1/zimm field.
  assign wants_write = is_rw || (instr_q[19:15] != 5'd0);

`ifdef CSR_RO_TRAP_EN
  assign ro_viol = wants_write && (instr_q[31:30] == 2'b11);
`else
  assign ro_viol = 1'b0;
`endif

  assign illegal_c = (instr_q[6:0] != OPC_SYSTEM) || (funct3[1:0] == 2'b00) || ro_viol;
  assign new_c     = csr_rmw(funct3[1:0], csr_rdata, operand_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ: begin
        if (illegal_c)        state_d = S_RESP;
        else if (wants_write) state_d = S_WRITE;
        else                  state_d = S_RESP;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction/operand latch at accept; old value, new value and verdict captured in READ
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= '0;
      operand_q <= '0;
      old_q     <= '0;
      new_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        instr_q   <= req_instr;
        operand_q <= req_instr[14] ? {{(XLEN-5){1'b0}}, req_instr[19:15]} : req_rs1_val;
      end
      if (state_q == S_READ) begin
        old_q     <= csr_rdata;
        new_q     <= new_c;
        illegal_q <= illegal_c;
      end
    end
  end

  // Outputs decoded from state; write enable and handshakes are masked while reset is high
  always_comb begin
    req_ready    = (state_q == S_IDLE) && !reset;
    resp_valid   = (state_q == S_RESP) && !reset;
    resp_illegal = (state_q == S_RESP) && illegal_q;
    resp_rd_we   = (state_q == S_RESP) && !illegal_q && (instr_q[11:7] != 5'd0);
    resp_rd_addr = instr_q[11:7];
    resp_rd_val  = old_q;
    csr_instr    = instr_q;
    csr_wd       = new_q;
    csr_ctrl     = 4'b0000;
    if ((state_q == S_WRITE) && !reset) csr_ctrl = {1'b1, funct3};
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed table-driven bench for csr_access_unit plus hand-written sequences for
// reset behaviour and response backpressure.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_instr;
  logic [31:0] req_rs1_val;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd_addr;
  logic        resp_rd_we;
  logic [31:0] resp_rd_val;
  logic        resp_illegal;
  logic [3:0]  csr_ctrl;
  logic [31:0] csr_instr;
  logic [31:0] csr_wd;
  logic [31:0] csr_rdata;

  int n_cmp = 0;
  int n_err = 0;

  csr_access_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_rs1_val(req_rs1_val),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd_addr(resp_rd_addr), .resp_rd_we(resp_rd_we),
    .resp_rd_val(resp_rd_val), .resp_illegal(resp_illegal),
    .csr_ctrl(csr_ctrl), .csr_instr(csr_instr),
    .csr_wd(csr_wd), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rdata;
    logic        wr;
    logic [3:0]  ctrl;
    logic [31:0] wd;
    logic [31:0] rd_val;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] opc);
    return {csr, rs1, f3, rd, opc};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rs1,
                              input logic [31:0] rdata, input logic wr,
                              input logic [3:0] ctrl, input logic [31:0] wd,
                              input logic we, input logic ill);
    vec_t v;
    v.instr = instr; v.rs1 = rs1; v.rdata = rdata; v.wr = wr; v.ctrl = ctrl;
    v.wd = wd; v.rd_val = rdata; v.rd = instr[11:7]; v.we = we; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".resp_valid"},   32'(resp_valid),   32'd0);
    chk({tag, ".resp_rd_we"},   32'(resp_rd_we),   32'd0);
    chk({tag, ".resp_illegal"}, 32'(resp_illegal), 32'd0);
    chk({tag, ".resp_rd_val"},  resp_rd_val,       32'd0);
    chk({tag, ".resp_rd_addr"}, 32'(resp_rd_addr), 32'd0);
    chk({tag, ".csr_ctrl"},     32'(csr_ctrl),     32'd0);
    chk({tag, ".csr_wd"},       csr_wd,            32'd0);
    chk({tag, ".csr_instr"},    csr_instr,         32'd0);
  endtask

  // Issue one request and check the write cycle, latency and response.
  task automatic run_vec(input vec_t v, input string tag, input bit hold);
    int cyc;
    int writes;
    logic [3:0]  seen_ctrl;
    logic [31:0] seen_wd;
    bit got;
    @(negedge clk);
    chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_instr = v.instr; req_rs1_val = v.rs1; csr_rdata = v.rdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_instr = 32'h0; req_rs1_val = 32'h0;
    cyc = 0; writes = 0; got = 1'b0; seen_ctrl = 4'h0; seen_wd = 32'h0;
    for (int k = 0; k < 8; k++) begin
      cyc++;
      if (csr_ctrl[3]) begin
        writes++; seen_ctrl = csr_ctrl; seen_wd = csr_wd;
      end
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      chk({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    if (!got) begin
      chk({tag, ".resp_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, ".latency"}, 32'(cyc), v.wr ? 32'd3 : 32'd2);
    chk({tag, ".write_cycles"}, 32'(writes), v.wr ? 32'd1 : 32'd0);
    if (v.wr) begin
      chk({tag, ".csr_ctrl"}, 32'(seen_ctrl), 32'(v.ctrl));
      chk({tag, ".csr_wd"}, seen_wd, v.wd);
    end
    chk({tag, ".rd_val"}, resp_rd_val, v.rd_val);
    chk({tag, ".rd_addr"}, 32'(resp_rd_addr), 32'(v.rd));
    chk({tag, ".rd_we"}, 32'(resp_rd_we), 32'(v.we));
    chk({tag, ".illegal"}, 32'(resp_illegal), 32'(v.ill));
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        req_valid = 1'b1; req_instr = enc(12'h300, 5'd1, 3'b001, 5'd9, 7'h73);
        req_rs1_val = 32'h1234_5678;
        @(posedge clk); #1;
        chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, ".hold_rd_val"}, resp_rd_val, v.rd_val);
        chk({tag, ".hold_rd_addr"}, 32'(resp_rd_addr), 32'(v.rd));
        chk({tag, ".hold_rd_we"}, 32'(resp_rd_we), 32'(v.we));
        chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".hold_no_write"}, 32'(csr_ctrl[3]), 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".released_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".released_ready"}, 32'(req_ready), 32'd1);
    if (hold) begin
      @(posedge clk); #1;
      chk({tag, ".stray_not_accepted"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_instr = 32'h0; req_rs1_val = 32'h0;
    resp_ready = 1'b0; csr_rdata = 32'h0;

    // csrrw x5, 0x300, x6
    vecs.push_back(mk(enc(12'h300, 5'd6, 3'b001, 5'd5, 7'h73), 32'hDEADBEEF, 32'h11,
                      1, 4'b1001, 32'hDEADBEEF, 1, 0));
    // csrrs x7, 0x305, x0 : read only
    vecs.push_back(mk(enc(12'h305, 5'd0, 3'b010, 5'd7, 7'h73), 32'h0000_1234, 32'h80,
                      0, 4'b0000, 32'h0, 1, 0));
    // csrrci x0, 0x300, 5
    vecs.push_back(mk(enc(12'h300, 5'd5, 3'b111, 5'd0, 7'h73), 32'hFFFF_FFFF, 32'hFF,
                      1, 4'b1111, 32'hFA, 0, 0));
    // funct3=100 illegal
    vecs.push_back(mk(enc(12'h300, 5'd2, 3'b100, 5'd3, 7'h73), 32'hAAAA_5555, 32'h55,
                      0, 4'b0000, 32'h0, 0, 1));
    // funct3=000 illegal
    vecs.push_back(mk(enc(12'h341, 5'd2, 3'b000, 5'd3, 7'h73), 32'h1, 32'h66,
                      0, 4'b0000, 32'h0, 0, 1));
    // wrong opcode with csrrw encoding illegal
    vecs.push_back(mk(enc(12'h300, 5'd6, 3'b001, 5'd5, 7'h33), 32'h1, 32'h77,
                      0, 4'b0000, 32'h0, 0, 1));
    // csrrs x1, 0x340, x3
    vecs.push_back(mk(enc(12'h340, 5'd3, 3'b010, 5'd1, 7'h73), 32'h0000_0F01, 32'h0000_F0F0,
                      1, 4'b1010, 32'h0000_FFF1, 1, 0));
    // csrrc x2, 0x340, x4
    vecs.push_back(mk(enc(12'h340, 5'd4, 3'b011, 5'd2, 7'h73), 32'h0000_00F0, 32'h0000_FFFF,
                      1, 4'b1011, 32'h0000_FF0F, 1, 0));
    // csrrwi x9, 0x300, 0 : writes even with zimm 0
    vecs.push_back(mk(enc(12'h300, 5'd0, 3'b101, 5'd9, 7'h73), 32'hFFFF_FFFF, 32'h77,
                      1, 4'b1101, 32'h0, 1, 0));
    // csrrsi x10, 0x300, 31
    vecs.push_back(mk(enc(12'h300, 5'd31, 3'b110, 5'd10, 7'h73), 32'h0, 32'h100,
                      1, 4'b1110, 32'h11F, 1, 0));
    // csrrsi x11, 0x300, 0 : no write
    vecs.push_back(mk(enc(12'h300, 5'd0, 3'b110, 5'd11, 7'h73), 32'hFFFF_FFFF, 32'h3C,
                      0, 4'b0000, 32'h0, 1, 0));
`ifdef CSR_RO_TRAP_EN
    // csrrw x4, 0xC00, x1 : write to read-only space traps
    vecs.push_back(mk(enc(12'hC00, 5'd1, 3'b001, 5'd4, 7'h73), 32'h1, 32'hABC,
                      0, 4'b0000, 32'h0, 0, 1));
`else
    vecs.push_back(mk(enc(12'hC00, 5'd1, 3'b001, 5'd4, 7'h73), 32'h1, 32'hABC,
                      1, 4'b1001, 32'h1, 1, 0));
`endif
    // csrrs x8, 0xC00, x0 : read of read-only CSR stays legal
    vecs.push_back(mk(enc(12'hC00, 5'd0, 3'b010, 5'd8, 7'h73), 32'h5, 32'h1234,
                      0, 4'b0000, 32'h0, 1, 0));

    // Reset state, with a request presented during reset that must be dropped
    @(negedge clk);
    req_valid = 1'b1; req_instr = enc(12'h300, 5'd6, 3'b001, 5'd5, 7'h73);
    req_rs1_val = 32'hCAFE_F00D;
    @(posedge clk); #1;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    chk("rst.dropped_ready", 32'(req_ready), 32'd1);
    chk("rst.dropped_instr", csr_instr, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i), 1'b0);

    // Backpressure: hold resp_ready low three cycles in RESP
    run_vec(vecs[0], "bp", 1'b1);

    // Reset during the READ cycle of a csrrw
    @(negedge clk);
    req_valid = 1'b1; req_instr = vecs[0].instr; req_rs1_val = vecs[0].rs1;
    csr_rdata = vecs[0].rdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    chk("midrst.read_cycle_we", 32'(csr_ctrl[3]), 32'd0);
    chk("midrst.csr_instr_latched", csr_instr, vecs[0].instr);
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    chk("midrst.no_write_later", 32'(csr_ctrl[3]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst.post_we", 32'(csr_ctrl[3]), 32'd0);
    chk("midrst.post_resp", 32'(resp_valid), 32'd0);
    run_vec(vecs[2], "after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Sequencer that executes one Zicsr instruction against the CSR register file.
- Accepts a CSR instruction plus its rs1 value from the datapath over a valid/ready handshake.
- Reads the addressed CSR, computes the read-modify-write value, issues the file's write-port control, and returns the old value for register writeback over a second valid/ready handshake.
- Sits between the decode/execute stage and the CSR register file. It drives the file's control, instruction and write-data inputs and consumes its combinational read data.

Parameters:
- XLEN, 32, data width of CSRs, rs1 operand and writeback value.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CSR instruction request valid
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_instr  input  32  full CSR instruction word
- req_rs1_val  input  XLEN  value of register rs1
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- resp_rd_addr  output  5  destination register (instr[11:7])
- resp_rd_we  output  1  writeback required
- resp_rd_val  output  XLEN  old CSR value
- resp_illegal  output  1  illegal-instruction flag for this request
- csr_ctrl  output  4  to CSR file: bit3 = write enable, bits2:0 = funct3
- csr_instr  output  32  to CSR file: latched instruction (address in [31:20], zimm in [19:15])
- csr_wd  output  XLEN  to CSR file: new value
- csr_rdata  input  XLEN  from CSR file: combinational read of addressed CSR

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Reset (synchronous, active-high) forces IDLE.
- Reset values: resp_valid=0, resp_rd_we=0, resp_illegal=0, resp_rd_val=0, resp_rd_addr=0, csr_ctrl=0, csr_wd=0, csr_instr=0.
- While reset is high, csr_ctrl[3]=0 unconditionally. Requests presented during reset are dropped.
- req_ready = (state==IDLE) and not reset.
- IDLE: on req_valid && req_ready, latch instr. Latch operand: if funct3[2]=1, operand is zimm zero-extended to XLEN; otherwise operand is req_rs1_val. Go to READ.
- READ (1 cycle): csr_instr = latched instr, csr_ctrl = 0. Capture csr_rdata into old_q.
- READ illegal check: opcode != 7'b1110011, or funct3 in {000, 100}. Illegal -> go to RESP with illegal=1, no write.
- READ new value: funct3[1:0]=01 -> operand; 10 -> old | operand; 11 -> old & ~operand.
- READ write decision: csrrw/csrrwi always write. csrrs/csrrc/csrrsi/csrrci write only if instr[19:15] != 0. Write -> WRITE, else -> RESP.
- WRITE (exactly 1 cycle): csr_ctrl = {1, funct3}, csr_wd = new_q, csr_instr held. Then RESP.
- RESP: resp_valid=1. resp_rd_val = old_q. resp_rd_addr = instr[11:7]. resp_rd_we = (rd != 0) && !illegal. Hold all resp outputs stable until resp_ready, then go to IDLE with resp_valid deasserted.
- Latency from the accept edge: resp_valid high 3 cycles later when a write occurs, 2 cycles later otherwise.
- Throughput: at most one instruction per 4 cycles (3 without a write) plus any response backpressure.
- csr_ctrl[3] is high only in WRITE, for exactly one cycle per instruction, never for illegal requests.
- CSR read happens even when rd = x0 (the file has no read side effects).
- Reset mid-operation: any state returns to IDLE on the next edge. No write is issued in or after the reset cycle. A pending response is discarded.
- Arithmetic is bitwise only; no width growth. zimm is zero-extended.

Optional Feature:
- Macro: CSR_RO_TRAP_EN.
- Defined: in READ, a request that would write (per the write decision) to an address with instr[31:30]==2'b11 (read-only CSR space) is illegal. It goes to RESP with resp_illegal=1, resp_rd_we=0, and no WRITE cycle. A read-only access that does not write (e.g. csrrs with rs1=x0) remains legal.
- Undefined: no read-only check; such writes proceed normally.

Test Plan:
- csrrw rd=x5, rs1=x6, csr 0x300 holding 0x00000011, req_rs1_val=0xDEADBEEF -> one cycle csr_ctrl=4'b1001 with csr_wd=0xDEADBEEF; resp_valid 3 cycles after accept with rd_val=0x11, rd_addr=5, rd_we=1, illegal=0.
- csrrs rd=x7, rs1=x0, csr 0x305 = 0x80 -> csr_ctrl[3] never asserted; resp_valid 2 cycles after accept, rd_val=0x80, rd_we=1.
- csrrci rd=x0, zimm=5, csr 0x300 = 0xFF -> write csr_wd=0xFA with csr_ctrl=4'b1111; resp rd_we=0.
- funct3=100 with any operands -> no write; resp_illegal=1, rd_we=0. With CSR_RO_TRAP_EN: csrrw to 0xC00 -> illegal, no write; without the macro: write issued.
- Hold resp_ready=0 for 3 cycles in RESP -> resp outputs stable, req_ready=0, a new req_valid is not accepted; resp_ready=1 -> IDLE next cycle, req_ready=1.
- Assert reset during the READ cycle of a csrrw -> csr_ctrl[3] stays 0, all outputs at reset values, next request accepted normally after reset deasserts.
